// File: rtl/serial_pattern_detector_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_detector_if
//  Purpose  : Control, data and status bundle of the serial pattern detector.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_pattern_detector_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic             clr;
   logic             d;
   logic             hit;
   logic [CNT_W-1:0] hit_cnt;
   logic             armed;

   modport master (
      output en, clr, d,
      input  hit, hit_cnt, armed
   );

   modport slave (
      input  en, clr, d,
      output hit, hit_cnt, armed
   );
endinterface
`default_nettype wire

// File: rtl/serial_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_detector
//  Purpose  : Detects a PAT_LEN-bit pattern (MSB first) in the sampled serial
//             stream; one-cycle hit pulse plus saturating hit counter.
//  Revision : 1.0  initial release
// ============================================================================
module serial_pattern_detector #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input logic                      clk,
   input logic                      rst_n,
   serial_pattern_detector_if.slave bus
);

   localparam int                  c_fill_w  = $clog2(PAT_LEN + 1);
   localparam logic [c_fill_w-1:0] c_full    = c_fill_w'(PAT_LEN);
   localparam logic [c_fill_w-1:0] c_last    = c_fill_w'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]    c_cnt_max = '1;

   typedef enum logic [0:0] {
      S_FILLING = 1'b0,
      S_ARMED   = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PAT_LEN-1:0]   r_shreg;
   logic [PAT_LEN-1:0]   w_shreg_nxt;
   logic [PAT_LEN-1:0]   w_shift;
   logic [c_fill_w-1:0]  r_fill;
   logic [c_fill_w-1:0]  w_fill_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 r_hit;
   logic                 w_hit_nxt;
   logic                 w_match;

   always_ff @(posedge clk) begin
      if (!rst_n || bus.clr) begin
         r_state <= S_FILLING;
         r_shreg <= '0;
         r_fill  <= '0;
         r_cnt   <= '0;
         r_hit   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_fill  <= w_fill_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hit   <= w_hit_nxt;
      end
   end

   // The match looks at the history including the bit being sampled now,
   // so the pulse appears right after the edge that takes the last bit.
   always_comb begin
      w_shreg_nxt = r_shreg;
      w_fill_nxt  = r_fill;
      w_cnt_nxt   = r_cnt;
      w_hit_nxt   = 1'b0;
      w_shift     = {r_shreg[PAT_LEN-2:0], bus.d};
      w_match     = (r_fill >= c_last) && (w_shift == PATTERN);

      if (bus.en) begin
         w_shreg_nxt = w_shift;
         w_hit_nxt   = w_match;
         if (w_match && (r_cnt != c_cnt_max)) begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
         if (w_match && !OVERLAP) begin
            w_fill_nxt = '0;
         end else if (r_fill != c_full) begin
            w_fill_nxt = r_fill + 1'b1;
         end
      end

      w_state_nxt = (w_fill_nxt == c_full) ? S_ARMED : S_FILLING;
   end

   assign bus.hit     = r_hit;
   assign bus.hit_cnt = r_cnt;
   assign bus.armed   = (r_state == S_ARMED);

endmodule
`default_nettype wire
